// File: rtl/terrain_gen_param.sv
// terrain_gen_param: LFSR random-walk height map generator with crater carving and two 1-cycle read ports
// Ports: clk, reset (async active-low); gen_start/seed start map generation;
// crater_start/crater_x/crater_r start a crater carve; busy/done/map_valid report status;
// rd_addr_a/rd_height_a (render) and rd_addr_b/rd_height_b (collision) are registered read ports.
module terrain_gen_param #(
    parameter int COLS      = 640,
    parameter int H_BITS    = 10,
    parameter int MIN_H     = 100,
    parameter int MAX_H     = 400,
    parameter int START_H   = 240,
    parameter int STEP_BITS = 3,
    parameter int AW        = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gen_start,
    input  logic [15:0]       seed,
    input  logic              crater_start,
    input  logic [AW-1:0]     crater_x,
    input  logic [7:0]        crater_r,
    output logic              busy,
    output logic              done,
    output logic              map_valid,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [H_BITS-1:0] rd_height_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [H_BITS-1:0] rd_height_b
);
    // crater arithmetic must hold crater_x +/- 255 without wrapping
    localparam int CW = (AW > 8 ? AW : 8) + 2;
    localparam int DW = CW + H_BITS;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [AW-1:0] LAST = AW'(COLS - 1);
    localparam logic signed [CW-1:0] LAST_W = CW'(COLS - 1);
    localparam logic signed [H_BITS:0] LO_H = (H_BITS + 1)'(MIN_H);
    localparam logic signed [H_BITS:0] HI_H = (H_BITS + 1)'(MAX_H);
    localparam logic signed [H_BITS:0] HALF = (H_BITS + 1)'(2 ** (STEP_BITS - 1));

    typedef enum logic [2:0] {IDLE, GEN, CR_RD, CR_WR, FIN} state_t;

    state_t               state;
    logic [AW-1:0]        col, hi, cx, lo, hi_c;
    logic [7:0]           cr;
    logic [H_BITS-1:0]    h, rd_old, carved;
    logic [15:0]          lfsr;
    logic                 from_gen, we;
    logic [H_BITS-1:0]    mem [COLS];
    logic signed [H_BITS:0] step, hs, h_next;
    logic signed [CW-1:0] lo_s, hi_s, dd, ad, d;

    always_comb begin
        step   = $signed((H_BITS + 1)'(lfsr[STEP_BITS-1:0])) - HALF;
        hs     = $signed({1'b0, h}) + step;
        h_next = hs < LO_H ? LO_H : hs > HI_H ? HI_H : hs;
        lo_s   = $signed(CW'(crater_x)) - $signed(CW'(crater_r));
        hi_s   = $signed(CW'(crater_x)) + $signed(CW'(crater_r));
        lo     = lo_s[CW-1] ? '0 : AW'(lo_s);
        hi_c   = hi_s > LAST_W ? LAST : AW'(hi_s);
        dd     = $signed(CW'(col)) - $signed(CW'(cx));
        ad     = dd[CW-1] ? -dd : dd;
        // inside [lo,hi] the distance never exceeds r, so d is non-negative
        d      = $signed(CW'(cr)) - ad;
        carved = DW'(rd_old) > DW'(d) ? H_BITS'(DW'(rd_old) - DW'(d)) : '0;
        we     = state == GEN || state == CR_WR;
    end

    // RAM: rd_old is captured every cycle; it is consumed in the CR_WR following CR_RD
    always_ff @(posedge clk) begin
        if (we) mem[col] <= state == GEN ? h : carved;
        rd_old <= mem[col];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            map_valid   <= 1'b0;
            rd_height_a <= '0;
            rd_height_b <= '0;
            lfsr        <= LFSR_INIT;
            col         <= '0;
            hi          <= '0;
            cx          <= '0;
            cr          <= '0;
            h           <= '0;
            from_gen    <= 1'b0;
        end else begin
            rd_height_a <= mem[rd_addr_a];
            rd_height_b <= mem[rd_addr_b];
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (gen_start) begin
                        state    <= GEN;
                        busy     <= 1'b1;
                        col      <= '0;
                        h        <= H_BITS'(START_H);
                        lfsr     <= seed == 16'h0 ? LFSR_INIT : seed;
                        from_gen <= 1'b1;
                    end else if (crater_start && map_valid) begin
                        state    <= CR_RD;
                        busy     <= 1'b1;
                        col      <= lo;
                        hi       <= hi_c;
                        cx       <= crater_x;
                        cr       <= crater_r;
                        from_gen <= 1'b0;
                    end
                end
                GEN: begin
                    h    <= H_BITS'(h_next);
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    col  <= col + AW'(1);
                    if (col == LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                CR_RD: state <= CR_WR;
                CR_WR: begin
                    if (col == hi) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        col   <= col + AW'(1);
                        state <= CR_RD;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (from_gen) map_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_terrain_gen_param.sv
// tb_terrain_gen_param: directed table-driven checks of generation, clamping, craters and reset abort
module tb_terrain_gen_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  gen_start, crater_start, busy, done, mv;
    logic [15:0] seed;
    logic [3:0]  crater_x, rd_addr_a, rd_addr_b;
    logic [7:0]  crater_r;
    logic [9:0]  ha0, hb0, ha1, hb1;
    int checks = 0;
    int errors = 0;
    int exp_map[16];

    typedef struct {int col; int h;} vec_t;
    vec_t cr_a[9];
    vec_t cr_b[9];
    int s1[16];

    always #5 clk = ~clk;

    terrain_gen_param #(.COLS(16)) dut0 (
        .clk(clk), .reset(reset), .gen_start(gen_start[0]), .seed(seed),
        .crater_start(crater_start[0]), .crater_x(crater_x), .crater_r(crater_r),
        .busy(busy[0]), .done(done[0]), .map_valid(mv[0]),
        .rd_addr_a(rd_addr_a), .rd_height_a(ha0), .rd_addr_b(rd_addr_b), .rd_height_b(hb0)
    );

    terrain_gen_param #(.COLS(16), .MIN_H(200), .MAX_H(200), .START_H(200)) dut1 (
        .clk(clk), .reset(reset), .gen_start(gen_start[1]), .seed(seed),
        .crater_start(crater_start[1]), .crater_x(crater_x), .crater_r(crater_r),
        .busy(busy[1]), .done(done[1]), .map_valid(mv[1]),
        .rd_addr_a(rd_addr_a), .rd_height_a(ha1), .rd_addr_b(rd_addr_b), .rd_height_b(hb1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic start(input int u, input bit g, input bit c, input logic [15:0] s, input int x, input int r);
        @(negedge clk);
        seed = s;
        crater_x = 4'(x);
        crater_r = 8'(r);
        gen_start[u] = g;
        crater_start[u] = c;
        @(negedge clk);
        gen_start = '0;
        crater_start = '0;
        chk("busy_rise", int'(busy[u]), 1);
    endtask

    task automatic wait_op(input int u, input int exp_n, input string nm);
        int n, dn;
        n = 0;
        dn = 0;
        while (busy[u] && n < 2000) begin
            n++;
            if (done[u]) dn++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, n, exp_n);
        chk({nm, "_done_pulses"}, dn, 1);
        chk({nm, "_done_low"}, int'(done[u]), 0);
    endtask

    task automatic read2(input int u, input int a, input int b, output int va, output int vb);
        @(negedge clk);
        rd_addr_a = 4'(a);
        rd_addr_b = 4'(b);
        @(negedge clk);
        va = u == 0 ? int'(ha0) : int'(ha1);
        vb = u == 0 ? int'(hb0) : int'(hb1);
    endtask

    task automatic check_map(input int u, input string nm);
        int va, vb;
        for (int i = 0; i < 16; i++) begin
            read2(u, i, 15 - i, va, vb);
            chk($sformatf("%s_a[%0d]", nm, i), va, exp_map[i]);
            chk($sformatf("%s_b[%0d]", nm, 15 - i), vb, exp_map[15 - i]);
        end
    endtask

    task automatic model(input logic [15:0] s);
        logic [15:0] l;
        int h;
        l = s == 16'h0 ? 16'hACE1 : s;
        h = 240;
        for (int c = 0; c < 16; c++) begin
            exp_map[c] = h;
            h = h + int'(l[2:0]) - 4;
            if (h < 100) h = 100;
            if (h > 400) h = 400;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    task automatic load_s1();
        for (int i = 0; i < 16; i++) exp_map[i] = s1[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int va, vb, n;
        s1 = '{240, 237, 235, 235, 231, 227, 223, 219, 215, 211, 207, 203, 200, 198, 199, 198};
        cr_a = '{'{4, 231}, '{5, 227}, '{6, 222}, '{7, 217}, '{8, 212},
                 '{9, 209}, '{10, 206}, '{11, 203}, '{12, 200}};
        cr_b = '{'{0, 236}, '{1, 232}, '{2, 231}, '{3, 232}, '{4, 229},
                 '{5, 226}, '{6, 223}, '{7, 219}, '{15, 198}};
        reset = 1'b0;
        gen_start = '0;
        crater_start = '0;
        seed = '0;
        crater_x = '0;
        crater_r = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_map_valid", int'(mv[0]), 0);
        chk("rst_rd_a", int'(ha0), 0);
        chk("rst_rd_b", int'(hb0), 0);
        reset = 1'b1;
        @(negedge clk);
        crater_x = 4'd8;
        crater_r = 8'd3;
        crater_start[0] = 1'b1;
        @(negedge clk);
        crater_start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("crater_no_map_busy", int'(busy[0]), 0);
            @(negedge clk);
        end
        start(0, 1'b1, 1'b0, 16'h0001, 0, 0);
        chk("gen_map_valid_low", int'(mv[0]), 0);
        wait_op(0, 17, "gen1");
        chk("gen1_map_valid", int'(mv[0]), 1);
        load_s1();
        check_map(0, "seed1");
        start(0, 1'b0, 1'b1, 16'h0, 8, 3);
        wait_op(0, 15, "crater8");
        for (int i = 0; i < 9; i++) begin
            read2(0, cr_a[i].col, cr_a[i].col, va, vb);
            chk($sformatf("crater8_a[%0d]", cr_a[i].col), va, cr_a[i].h);
            chk($sformatf("crater8_b[%0d]", cr_a[i].col), vb, cr_a[i].h);
        end
        start(0, 1'b1, 1'b1, 16'h0001, 8, 3);
        wait_op(0, 17, "gen_and_crater");
        repeat (3) @(negedge clk);
        chk("gen_and_crater_idle", int'(busy[0]), 0);
        check_map(0, "gen_wins");
        start(0, 1'b0, 1'b1, 16'h0, 1, 5);
        wait_op(0, 14 + 1, "crater1");
        for (int i = 0; i < 9; i++) begin
            read2(0, cr_b[i].col, 15 - cr_b[i].col, va, vb);
            chk($sformatf("crater1[%0d]", cr_b[i].col), va, cr_b[i].h);
        end
        start(0, 1'b1, 1'b0, 16'h0000, 0, 0);
        wait_op(0, 17, "gen_seed0");
        model(16'hACE1);
        check_map(0, "seed0");
        start(0, 1'b1, 1'b0, 16'hACE1, 0, 0);
        wait_op(0, 17, "gen_ace1");
        check_map(0, "seedace1");
        model(16'h1234);
        for (int k = 0; k < 2; k++) begin
            start(0, 1'b1, 1'b0, 16'h1234, 0, 0);
            wait_op(0, 17, "gen_1234");
            check_map(0, $sformatf("seed1234_run%0d", k));
        end
        start(1, 1'b1, 1'b0, 16'h5A5A, 0, 0);
        wait_op(1, 17, "clamp_gen");
        for (int i = 0; i < 16; i++) exp_map[i] = 200;
        check_map(1, "clamp");
        start(1, 1'b0, 1'b1, 16'h0, 8, 255);
        wait_op(1, 33, "crater_sat");
        for (int i = 0; i < 16; i++) exp_map[i] = 0;
        check_map(1, "saturate");
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd1;
        start(0, 1'b1, 1'b0, 16'h0001, 0, 0);
        repeat (7) @(negedge clk);
        chk("pre_abort_busy", int'(busy[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_map_valid", int'(mv[0]), 0);
        chk("abort_rd_a", int'(ha0), 0);
        chk("abort_rd_b", int'(hb0), 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done[0] || busy[0] || mv[0]) n++;
        end
        chk("abort_quiet", n, 0);
        start(0, 1'b1, 1'b0, 16'h0001, 0, 0);
        wait_op(0, 17, "regen");
        chk("regen_map_valid", int'(mv[0]), 1);
        load_s1();
        check_map(0, "regen");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
